// File: rtl/f11_useq_pkg.sv
// Shared definitions for the F11 microsequencer: sequencing opcodes, microword
// field positions, sequencer state encoding and the subroutine entry helper.
package f11_useq_pkg;

   typedef enum logic [2:0] {
      SEQ_NEXT = 3'd0,
      SEQ_BR   = 3'd1,
      SEQ_DISP = 3'd2,
      SEQ_CALL = 3'd3,
      SEQ_RET  = 3'd4,
      SEQ_WAIT = 3'd5,
      SEQ_TACK = 3'd6,
      SEQ_RSVD = 3'd7
   } seq_e;

   typedef enum logic {
      RST = 1'b0,
      RUN = 1'b1
   } state_e;

   localparam int SEQ_MSB = 15;
   localparam int SEQ_LSB = 13;
   localparam int OP_MSB  = 12;
   localparam int OP_LSB  = 10;

   localparam logic [3:0] SUB_BASE = 4'b1111;

   // Subroutines live on a 4-word grid at the top of the microaddress space.
   function automatic logic [8:0] sub_entry(input logic [2:0] op);
      return {SUB_BASE, op, 2'b00};
   endfunction

endpackage

// File: rtl/dc_ustack.sv
// Microsubroutine return stack: shift-register LIFO, entry 0 is the top.
// A push when full drops the oldest entry off the bottom.
module dc_ustack #(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_din,
   output logic [DATA_W-1:0] o_top,
   output logic              o_full,
   output logic              o_empty
);

   localparam int             CNT_W   = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_mem [DEPTH];

   assign o_full  = (r_cnt == CNT_MAX);
   assign o_empty = (r_cnt == '0);
   assign o_top   = r_mem[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_push && !o_full) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (i_pop && !o_empty) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Entry contents need no reset: the count alone defines what is valid.
   always_ff @(posedge clk) begin
      if (!i_clr) begin
         if (i_push) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
         end else if (i_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
         end
      end
   end

endmodule

// File: rtl/dc_useq.sv
// F11 microsequencer: forms the next DC303 ROM address each enabled cycle
// from the registered microword, conditions, dispatch, return stack and traps.
module dc_useq
   import f11_useq_pkg::*;
#(
   parameter logic [8:0] RESET_VEC = 9'h000,
   parameter logic [8:0] TRAP_VEC  = 9'h1F0,
   parameter int         STK_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic        restart,
   input  logic [8:0]  rom_ma,
   input  logic [15:0] rom_mc,
   output logic [9:0]  rom_a,
   input  logic [7:0]  cond,
   input  logic [8:0]  pla_a,
   input  logic        ax,
   input  logic        trap_req,
   output logic [15:0] mir,
   output logic        mir_vld,
   output logic [8:0]  mpc,
   output logic        stk_err
);

   state_e     r_state;
   state_e     w_state_nxt;
   logic       r_ax_mode;
   logic       w_ax_nxt;
   logic       r_trap_pend;
   logic       w_trap_nxt;
   logic [8:0] r_mpc;
   logic       r_stk_err;
   logic       w_stk_err_nxt;
   logic       r_mir_vld;
   logic       w_vld_nxt;

   logic [8:0] w_addr;
   logic       w_ax_out;
   seq_e       w_seq;
   logic [2:0] w_op;

   logic       w_push;
   logic       w_pop;
   logic       w_clr;
   logic [8:0] w_stk_top;
   logic       w_stk_empty;
   logic       w_unused_stk_full;

   assign w_seq = seq_e'(rom_mc[SEQ_MSB:SEQ_LSB]);
   assign w_op  = rom_mc[OP_MSB:OP_LSB];

   dc_ustack #(
      .DATA_W (9),
      .DEPTH  (STK_DEPTH)
   ) u_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (cen & w_clr),
      .i_push  (cen & w_push),
      .i_pop   (cen & w_pop),
      .i_din   (rom_ma),
      .o_top   (w_stk_top),
      .o_full  (w_unused_stk_full),
      .o_empty (w_stk_empty)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_ax_nxt      = r_ax_mode;
      w_trap_nxt    = r_trap_pend | trap_req;
      w_stk_err_nxt = r_stk_err;
      w_vld_nxt     = 1'b1;
      w_addr        = RESET_VEC;
      w_ax_out      = 1'b0;
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_clr         = 1'b0;

      if (restart) begin
         w_state_nxt   = RST;
         w_ax_nxt      = 1'b0;
         w_trap_nxt    = 1'b0;
         w_stk_err_nxt = 1'b0;
         w_vld_nxt     = 1'b0;
         w_clr         = 1'b1;
      end else if (r_state == RST) begin
         w_state_nxt = RUN;
      end else begin
         w_ax_out = r_ax_mode;
         case (w_seq)
            SEQ_BR:   w_addr = {rom_ma[8:1], cond[w_op]};
            SEQ_DISP: begin
               w_addr   = r_trap_pend ? TRAP_VEC : pla_a;
               w_ax_nxt = ax;
               w_ax_out = ax;
            end
            SEQ_CALL: begin
               w_push = 1'b1;
               w_addr = sub_entry(w_op);
            end
            SEQ_RET: begin
               if (w_stk_empty) begin
                  w_addr        = RESET_VEC;
                  w_stk_err_nxt = 1'b1;
               end else begin
                  w_addr = w_stk_top;
                  w_pop  = 1'b1;
               end
            end
            SEQ_WAIT: w_addr = cond[w_op] ? rom_ma : r_mpc;
            SEQ_TACK: begin
               w_addr     = rom_ma;
               // A trap arriving on the acknowledge cycle must not be lost.
               w_trap_nxt = trap_req;
            end
            default:  w_addr = rom_ma;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RST;
         r_ax_mode   <= 1'b0;
         r_trap_pend <= 1'b0;
         r_mpc       <= RESET_VEC;
         r_stk_err   <= 1'b0;
         r_mir_vld   <= 1'b0;
      end else if (cen) begin
         r_state     <= w_state_nxt;
         r_ax_mode   <= w_ax_nxt;
         r_trap_pend <= w_trap_nxt;
         r_mpc       <= w_addr;
         r_stk_err   <= w_stk_err_nxt;
         r_mir_vld   <= w_vld_nxt;
      end
   end

   assign rom_a   = {w_ax_out, w_addr};
   assign mir     = rom_mc;
   assign mir_vld = r_mir_vld;
   assign mpc     = r_mpc;
   assign stk_err = r_stk_err;

endmodule

// File: tb/tb_dc_useq.sv
// Directed bench for dc_useq: table of single-microword steps in RUN plus
// hand-written reset, restart, clock-enable and async-reset sequences.
module tb_dc_useq;
   import f11_useq_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        cen;
   logic        restart;
   logic [8:0]  rom_ma;
   logic [15:0] rom_mc;
   logic [9:0]  rom_a;
   logic [7:0]  cond;
   logic [8:0]  pla_a;
   logic        ax;
   logic        trap_req;
   logic [15:0] mir;
   logic        mir_vld;
   logic [8:0]  mpc;
   logic        stk_err;

   int n_cmp  = 0;
   int n_fail = 0;

   dc_useq #(
      .RESET_VEC (9'h000),
      .TRAP_VEC  (9'h1F0),
      .STK_DEPTH (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .restart  (restart),
      .rom_ma   (rom_ma),
      .rom_mc   (rom_mc),
      .rom_a    (rom_a),
      .cond     (cond),
      .pla_a    (pla_a),
      .ax       (ax),
      .trap_req (trap_req),
      .mir      (mir),
      .mir_vld  (mir_vld),
      .mpc      (mpc),
      .stk_err  (stk_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] seq;
      logic [2:0] op;
      logic [8:0] ma;
      logic [7:0] cnd;
      logic [8:0] pla;
      logic       axr;
      logic       trq;
      logic [9:0] exp_a;
      logic       exp_err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic [2:0] s, input logic [2:0] o,
                               input logic [8:0] ma, input logic [7:0] c,
                               input logic [8:0] p, input logic a, input logic t,
                               input logic [9:0] ea, input logic ee);
      vec_t v;
      v.seq = s; v.op = o; v.ma = ma; v.cnd = c; v.pla = p;
      v.axr = a; v.trq = t; v.exp_a = ea; v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_uw(input logic [2:0] s, input logic [2:0] o, input logic [8:0] ma);
      rom_mc = {s, o, 10'h2A5};
      rom_ma = ma;
   endtask

   initial begin
      rst_n = 1'b0; cen = 1'b0; restart = 1'b0; cond = 8'h00;
      pla_a = 9'h000; ax = 1'b0; trap_req = 1'b0;
      set_uw(SEQ_CALL, 3'd5, 9'h1AA);

      //           seq       op    ma      cond   pla     ax  trq exp_a   err
      vq.push_back(mk(SEQ_NEXT, 3'd0, 9'h005, 8'h00, 9'h000, 0, 0, 10'h005, 0));
      vq.push_back(mk(SEQ_BR,   3'd3, 9'h040, 8'h08, 9'h000, 0, 0, 10'h041, 0));
      vq.push_back(mk(SEQ_BR,   3'd3, 9'h040, 8'hF7, 9'h000, 0, 0, 10'h040, 0));
      vq.push_back(mk(SEQ_CALL, 3'd2, 9'h123, 8'h00, 9'h000, 0, 0, 10'h1E8, 0));
      vq.push_back(mk(SEQ_RET,  3'd0, 9'h000, 8'h00, 9'h000, 0, 0, 10'h123, 0));
      vq.push_back(mk(SEQ_RSVD, 3'd0, 9'h0AA, 8'h00, 9'h000, 0, 0, 10'h0AA, 0));
      vq.push_back(mk(SEQ_NEXT, 3'd0, 9'h010, 8'h00, 9'h000, 0, 1, 10'h010, 0));
      vq.push_back(mk(SEQ_DISP, 3'd0, 9'h000, 8'h00, 9'h080, 0, 0, 10'h1F0, 0));
      vq.push_back(mk(SEQ_TACK, 3'd0, 9'h020, 8'h00, 9'h000, 0, 0, 10'h020, 0));
      vq.push_back(mk(SEQ_DISP, 3'd0, 9'h000, 8'h00, 9'h080, 1, 0, 10'h280, 0));
      vq.push_back(mk(SEQ_NEXT, 3'd0, 9'h033, 8'h00, 9'h000, 0, 0, 10'h233, 0));
      vq.push_back(mk(SEQ_TACK, 3'd0, 9'h044, 8'h00, 9'h000, 0, 1, 10'h244, 0));
      vq.push_back(mk(SEQ_DISP, 3'd0, 9'h000, 8'h00, 9'h080, 0, 0, 10'h1F0, 0));
      vq.push_back(mk(SEQ_TACK, 3'd0, 9'h050, 8'h00, 9'h000, 0, 0, 10'h050, 0));
      vq.push_back(mk(SEQ_DISP, 3'd0, 9'h000, 8'h00, 9'h081, 0, 0, 10'h081, 0));
      vq.push_back(mk(SEQ_WAIT, 3'd0, 9'h077, 8'hFE, 9'h000, 0, 0, 10'h081, 0));
      vq.push_back(mk(SEQ_WAIT, 3'd0, 9'h077, 8'hFE, 9'h000, 0, 0, 10'h081, 0));
      vq.push_back(mk(SEQ_WAIT, 3'd0, 9'h077, 8'hFE, 9'h000, 0, 0, 10'h081, 0));
      vq.push_back(mk(SEQ_WAIT, 3'd0, 9'h077, 8'h01, 9'h000, 0, 0, 10'h077, 0));
      vq.push_back(mk(SEQ_CALL, 3'd0, 9'h101, 8'h00, 9'h000, 0, 0, 10'h1E0, 0));
      vq.push_back(mk(SEQ_CALL, 3'd1, 9'h102, 8'h00, 9'h000, 0, 0, 10'h1E4, 0));
      vq.push_back(mk(SEQ_CALL, 3'd2, 9'h103, 8'h00, 9'h000, 0, 0, 10'h1E8, 0));
      vq.push_back(mk(SEQ_CALL, 3'd3, 9'h104, 8'h00, 9'h000, 0, 0, 10'h1EC, 0));
      vq.push_back(mk(SEQ_CALL, 3'd4, 9'h105, 8'h00, 9'h000, 0, 0, 10'h1F0, 0));
      vq.push_back(mk(SEQ_RET,  3'd0, 9'h000, 8'h00, 9'h000, 0, 0, 10'h105, 0));
      vq.push_back(mk(SEQ_RET,  3'd0, 9'h000, 8'h00, 9'h000, 0, 0, 10'h104, 0));
      vq.push_back(mk(SEQ_RET,  3'd0, 9'h000, 8'h00, 9'h000, 0, 0, 10'h103, 0));
      vq.push_back(mk(SEQ_RET,  3'd0, 9'h000, 8'h00, 9'h000, 0, 0, 10'h102, 0));
      vq.push_back(mk(SEQ_RET,  3'd0, 9'h000, 8'h00, 9'h000, 0, 0, 10'h000, 1));
      vq.push_back(mk(SEQ_NEXT, 3'd0, 9'h0AB, 8'h00, 9'h000, 0, 0, 10'h0AB, 1));

      // Reset state, with a non-NEXT microword on the ROM outputs
      #12;
      chk("rst_rom_a", 16'(rom_a), 16'h000);
      chk("rst_mir_vld", 16'(mir_vld), 16'h0);
      chk("rst_mpc", 16'(mpc), 16'h000);
      chk("rst_stk_err", 16'(stk_err), 16'h0);
      rst_n = 1'b1;
      next_cyc();
      chk("rst_hold_rom_a", 16'(rom_a), 16'h000);
      chk("rst_hold_vld", 16'(mir_vld), 16'h0);
      cen = 1'b1;
      next_cyc();
      set_uw(SEQ_NEXT, 3'd0, 9'h005);
      #2;
      chk("first_rom_a", 16'(rom_a), 16'h005);
      chk("first_mir_vld", 16'(mir_vld), 16'h1);
      chk("first_mpc", 16'(mpc), 16'h000);
      chk("first_mir", mir, {SEQ_NEXT, 3'd0, 10'h2A5});

      foreach (vq[i]) begin
         set_uw(vq[i].seq, vq[i].op, vq[i].ma);
         cond = vq[i].cnd; pla_a = vq[i].pla; ax = vq[i].axr; trap_req = vq[i].trq;
         #2;
         chk($sformatf("vec%0d_rom_a", i), 16'(rom_a), 16'(vq[i].exp_a));
         next_cyc();
         chk($sformatf("vec%0d_mpc", i), 16'(mpc), 16'(vq[i].exp_a[8:0]));
         chk($sformatf("vec%0d_stk_err", i), 16'(stk_err), 16'(vq[i].exp_err));
      end
      trap_req = 1'b0; ax = 1'b0; cond = 8'h00;

      // Restart in the middle of a CALL chain
      set_uw(SEQ_CALL, 3'd1, 9'h111);
      #2; chk("chain_call1", 16'(rom_a), 16'h1E4);
      next_cyc();
      set_uw(SEQ_CALL, 3'd2, 9'h112);
      #2; chk("chain_call2", 16'(rom_a), 16'h1E8);
      next_cyc();
      set_uw(SEQ_CALL, 3'd3, 9'h113);
      restart = 1'b1;
      #2; chk("restart_rom_a", 16'(rom_a), 16'h000);
      next_cyc();
      restart = 1'b0;
      #2;
      chk("restart_vld_low", 16'(mir_vld), 16'h0);
      chk("restart_err_clr", 16'(stk_err), 16'h0);
      chk("restart_rst_a", 16'(rom_a), 16'h000);
      next_cyc();
      set_uw(SEQ_RET, 3'd0, 9'h000);
      #2;
      chk("restart_vld_back", 16'(mir_vld), 16'h1);
      chk("restart_stk_empty", 16'(rom_a), 16'h000);
      next_cyc();
      chk("restart_underflow_err", 16'(stk_err), 16'h1);

      // Clock enable low holds state
      set_uw(SEQ_NEXT, 3'd0, 9'h155);
      cen = 1'b0;
      #2; chk("cen0_rom_a", 16'(rom_a), 16'h155);
      next_cyc();
      chk("cen0_mpc_hold", 16'(mpc), 16'h000);
      cen = 1'b1;
      next_cyc();
      chk("cen1_mpc", 16'(mpc), 16'h155);

      // Async reset between clock edges
      set_uw(SEQ_DISP, 3'd0, 9'h000);
      pla_a = 9'h090; ax = 1'b1;
      #2; chk("pre_rst_disp", 16'(rom_a), 16'h290);
      next_cyc();
      set_uw(SEQ_NEXT, 3'd0, 9'h0C0);
      ax = 1'b0;
      #2; chk("pre_rst_ax", 16'(rom_a), 16'h2C0);
      rst_n = 1'b0;
      #1;
      chk("arst_rom_a", 16'(rom_a), 16'h000);
      chk("arst_mir_vld", 16'(mir_vld), 16'h0);
      chk("arst_mpc", 16'(mpc), 16'h000);
      chk("arst_stk_err", 16'(stk_err), 16'h0);
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dc_useq.md
Name: dc_useq

Overview:
- Microsequencer for the F11 microcode path; sits directly upstream of the DC303 microcode ROM.
- Each clock-enabled cycle it computes the 10-bit ROM address from the ROM's registered outputs: 9-bit next-address field (ma), 16-bit microword (mc).
- Sources for the address: condition inputs, instruction-decode (PLA) dispatch, a microsubroutine return stack, pending traps and AX mode.
- Exposes the current microword with a valid flag to the datapath.

Parameters:
- RESET_VEC, 9'h000, microaddress issued after reset or restart.
- TRAP_VEC, 9'h1F0, microaddress substituted for a DISP when a trap is pending.
- STK_DEPTH, 4, return-stack entries (2..8).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; sequencer state advances only on cen
- restart  in  1  synchronous restart request, sampled on cen
- rom_ma  in  9  next-address field from ROM
- rom_mc  in  16  microword from ROM
- rom_a  out  10  ROM address {ax_mode, addr[8:0]}
- cond  in  8  microbranch/wait condition lines
- pla_a  in  9  dispatch address from instruction decoder
- ax  in  1  AX extension request, sampled at DISP
- trap_req  in  1  trap request pulse
- mir  out  16  current microword (rom_mc passthrough)
- mir_vld  out  1  mir holds a valid microword
- mpc  out  9  address of the microword currently in mir
- stk_err  out  1  sticky return-stack underflow flag

Behaviour:
- Reset values: state=RST, ax_mode=0, stack pointer=0, trap_pend=0, mpc=RESET_VEC, stk_err=0, mir_vld=0.
- States: RST -> RUN on first cen.
  - RST drives rom_a={1'b0,RESET_VEC}.
  - ROM latches on that same cen; mir_vld=1 from the next cycle.
- RUN: rom_a is combinational from rom_mc, rom_ma, cond, pla_a and internal state. No added latency, so one microinstruction per cen.
- All registers (mpc, stack, ax_mode, trap_pend) update only on cen.
- mpc <= issued addr[8:0] on every cen.
- Sequencing field SEQ=rom_mc[15:13], operand OP=rom_mc[12:10]:
  - 000 NEXT: addr=rom_ma.
  - 001 BR: addr={rom_ma[8:1], cond[OP]}.
  - 010 DISP: addr = trap_pend ? TRAP_VEC : pla_a; ax_mode<=ax.
  - 011 CALL: push rom_ma; addr={4'b1111, OP, 2'b00}.
  - 100 RET: addr=pop.
  - 101 WAIT: addr = cond[OP] ? rom_ma : mpc (re-issue self).
  - 110 TACK: addr=rom_ma; trap_pend<=0.
  - 111: treated as NEXT.
- rom_a[9] = ax_mode. On DISP, the new ax value already applies to the issued address (rom_a[9]=ax).
- Trap handling:
  - trap_req high on any cen sets trap_pend.
  - If trap_req and TACK occur on the same cen, set wins.
- Stack overflow: CALL when full shifts out the oldest entry; no error flagged.
- Stack underflow: RET when empty issues RESET_VEC and sets stk_err, which stays set until reset or restart.
- restart=1 on cen, any state:
  - next state RST; stack, trap_pend and ax_mode cleared; stk_err cleared.
  - rom_a=RESET_VEC on that cycle; mir_vld=0 for the following cycle.
- rst_n asserted mid-operation: immediate async return to reset values; rom_a=RESET_VEC combinationally.
- cen=0: outputs and state hold. rom_a may follow input changes, but is only consumed on cen.

Decomposition:
- Shared package f11_useq_pkg holds:
  - SEQ opcode constants (SEQ_NEXT..SEQ_TACK);
  - field positions (SEQ_MSB=15, SEQ_LSB=13, OP_MSB=12, OP_LSB=10);
  - state encoding RST/RUN;
  - the subroutine entry base 4'b1111.
- One sub-module, dc_ustack: a parameterised LIFO with push, pop, full, empty, shift-on-overflow and a synchronous clear.

Test Plan:
- Reset release, ROM model with mem[000]=NEXT->ma 005 -> rom_a=000 in RST, then 005 after first cen; mir_vld=1 one cen later; mpc=000.
- BR with OP=3, ma=0x40:
  - cond[3]=1 -> rom_a=0x041;
  - cond[3]=0 -> rom_a=0x040.
- CALL OP=2, ma=0x123 -> rom_a=0x1E8.
  - A RET at the subroutine then issues 0x123.
  - Five nested CALLs at STK_DEPTH=4 followed by five RETs -> the fifth RET issues RESET_VEC and stk_err=1.
- Trap and AX dispatch:
  - trap_req pulse, then DISP with pla_a=0x080 -> rom_a=0x1F0.
  - TACK clears trap_pend; the next DISP with ax=1 -> rom_a=0x280 and rom_a[9] stays 1.
- WAIT OP=0, cond[0]=0 for 3 cen cycles -> rom_a=mpc repeated 3 times; cond[0]=1 -> rom_a=ma.
- Mid-run events:
  - restart during a CALL chain -> rom_a=RESET_VEC, mir_vld low for one cen, stack empty, stk_err cleared.
  - async rst_n pulse between clocks -> immediate reset values.
